// File: rtl/control_sequencer.sv
// Multi-beat fetch/decode/execute control sequencer with a mem_ready handshake.
// Optional memory wait timeout: define CTRL_MEM_TIMEOUT_EN to enable the FAULT state.
module control_sequencer #(
  parameter int IR_BYTES   = 2,
  parameter int ADDR_BYTES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*IR_BYTES-1:0]   opcode,
  input  logic [2:0]              alu_flags,
  input  logic                    mem_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [IR_BYTES-1:0]     ir_load,
  output logic [ADDR_BYTES-1:0]   mar_load,
  output logic [ADDR_BYTES-1:0]   jr_load,
  output logic                    pc_increment,
  output logic                    pc_set,
  output logic                    gp_read,
  output logic                    gp_write,
  output logic [2:0]              gp_input_select,
  output logic [2:0]              gp_output_select,
  output logic [3:0]              alu_operation,
  output logic                    latch_alu,
  output logic                    busy,
  output logic                    fault
);

  localparam int MAXB = (IR_BYTES > ADDR_BYTES) ? IR_BYTES : ADDR_BYTES;
  localparam int CW   = $clog2(MAXB) + 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_ADDR      = 4'd3;
  localparam logic [3:0] S_MEM       = 4'd4;
  localparam logic [3:0] S_ALU       = 4'd5;
  localparam logic [3:0] S_STORE     = 4'd6;
  localparam logic [3:0] S_JUMP_ADDR = 4'd7;
  localparam logic [3:0] S_JUMP_EXEC = 4'd8;
  localparam logic [3:0] S_HALT      = 4'd9;
  localparam logic [3:0] S_FAULT     = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   op_s;
  logic          unused_op_s;

  // Narrow IR builds read the upper opcode fields as zero.
  assign op_s        = 32'(opcode);
  assign unused_op_s = ^{op_s[31:16], op_s[9:8]};

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          fault_q, fault_d;
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_load          = {IR_BYTES{1'b0}};
    mar_load         = {ADDR_BYTES{1'b0}};
    jr_load          = {ADDR_BYTES{1'b0}};
    pc_increment     = 1'b0;
    pc_set           = 1'b0;
    gp_read          = 1'b0;
    gp_write         = 1'b0;
    latch_alu        = 1'b0;
    gp_input_select  = op_s[4:2];
    gp_output_select = op_s[7:5];
    alu_operation    = op_s[13:10];
    busy             = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = {CW{1'b0}};
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_increment = 1'b1;
          for (int k = 0; k < IR_BYTES; k++) begin
            ir_load[k] = (cnt_q == CW'(IR_BYTES - 1 - k));
          end
          if (cnt_q == CW'(IR_BYTES - 1)) begin
            state_d = S_DECODE;
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DECODE: begin
        case (op_s[15:14])
          2'b00:   state_d = S_ALU;
          2'b01:   state_d = S_ADDR;
          2'b10:   state_d = S_JUMP_ADDR;
          2'b11:   state_d = S_HALT;
          default: state_d = S_HALT;
        endcase
        cnt_d = {CW{1'b0}};
      end
      S_ALU: begin
        gp_write  = 1'b1;
        latch_alu = 1'b1;
        state_d   = S_STORE;
      end
      S_STORE: begin
        gp_read = 1'b1;
        state_d = S_FETCH;
        cnt_d   = {CW{1'b0}};
      end
      S_ADDR, S_JUMP_ADDR: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_increment = 1'b1;
          for (int k = 0; k < ADDR_BYTES; k++) begin
            if (state_q == S_ADDR) begin
              mar_load[k] = (cnt_q == CW'(ADDR_BYTES - 1 - k));
            end else begin
              jr_load[k] = (cnt_q == CW'(ADDR_BYTES - 1 - k));
            end
          end
          if (cnt_q == CW'(ADDR_BYTES - 1)) begin
            state_d = (state_q == S_ADDR) ? S_MEM : S_JUMP_EXEC;
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_MEM: begin
        // opcode[13] selects store (drive bus from regfile) versus load.
        if (op_s[13]) begin
          mem_write = 1'b1;
          gp_write  = 1'b1;
        end else begin
          mem_read = 1'b1;
          gp_read  = mem_ready;
        end
        if (mem_ready) begin
          state_d = S_FETCH;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_MEM;
        end
      end
      S_JUMP_EXEC: begin
        case (op_s[1:0])
          2'b00:   pc_set = 1'b1;
          2'b01:   pc_set = alu_flags[0];
          2'b10:   pc_set = alu_flags[1];
          2'b11:   pc_set = alu_flags[2];
          default: pc_set = 1'b0;
        endcase
        state_d = S_FETCH;
        cnt_d   = {CW{1'b0}};
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

`ifdef CTRL_MEM_TIMEOUT_EN
    fault_d = fault_q;
    wait_d  = {WW{1'b0}};
    // Only consecutive stalled cycles in a handshake state count toward the limit.
    if ((state_q == S_FETCH || state_q == S_ADDR || state_q == S_MEM ||
         state_q == S_JUMP_ADDR) && !mem_ready) begin
      if (wait_q == WW'(TIMEOUT - 1)) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end else begin
        wait_d = wait_q + WW'(1);
      end
    end else begin
      wait_d = {WW{1'b0}};
    end
    fault = fault_q;
`else
    fault = 1'b0;
`endif
  end

  // State, beat counter and optional timeout registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
`ifdef CTRL_MEM_TIMEOUT_EN
      wait_q  <= {WW{1'b0}};
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CTRL_MEM_TIMEOUT_EN
      wait_q  <= wait_d;
      fault_q <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a transaction-level model predicts
// every observable strobe event, and a negedge monitor pops and compares them.
module tb_control_sequencer;
  localparam int IRB = 2;
  localparam int AB  = 2;
  localparam int TO  = 15;
  localparam int NI  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, mem_ready, mem_read, mem_write;
  logic [15:0] opcode;
  logic [2:0]  alu_flags;
  logic [IRB-1:0] ir_load;
  logic [AB-1:0]  mar_load, jr_load;
  logic pc_increment, pc_set, gp_read, gp_write, latch_alu, busy, fault;
  logic [2:0] gp_input_select, gp_output_select;
  logic [3:0] alu_operation;

  control_sequencer #(.IR_BYTES(IRB), .ADDR_BYTES(AB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_flags(alu_flags),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .ir_load(ir_load), .mar_load(mar_load), .jr_load(jr_load),
    .pc_increment(pc_increment), .pc_set(pc_set), .gp_read(gp_read), .gp_write(gp_write),
    .gp_input_select(gp_input_select), .gp_output_select(gp_output_select),
    .alu_operation(alu_operation), .latch_alu(latch_alu), .busy(busy), .fault(fault)
  );

  typedef struct packed {
    logic [12:0] strb;  // {mr, mw, ir[1:0], mar[1:0], jr[1:0], pc_inc, pc_set, gp_rd, gp_wr, latch}
    logic        chk;
    logic [9:0]  sel;   // {alu_operation, gp_input_select, gp_output_select}
  } ev_t;

  ev_t exp_q[$];
  logic [15:0] prog [NI];
  logic [2:0]  pflg [NI];
  int  checks, errors, idx, zrun;
  bit  run, sb_en, ir_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] pk(input logic mr, input logic mw, input logic [1:0] ir,
                                     input logic [1:0] mar, input logic [1:0] jr, input logic pi,
                                     input logic ps, input logic gr, input logic gw, input logic la);
    return {mr, mw, ir, mar, jr, pi, ps, gr, gw, la};
  endfunction

  task automatic push_ev(input logic [12:0] s, input logic c, input logic [15:0] op);
    ev_t e;
    e.strb = s;
    e.chk  = c;
    e.sel  = {op[13:10], op[4:2], op[7:5]};
    exp_q.push_back(e);
  endtask

  // Instruction fetch: IRB accepted read beats, MSB byte first, each advancing the PC.
  task automatic push_fetch();
    for (int k = 0; k < IRB; k++)
      push_ev(pk(1'b1, 1'b0, 2'(1) << (IRB - 1 - k), 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
              1'b0, 16'h0000);
  endtask

  task automatic push_exec(input int i);
    logic [15:0] op;
    logic [2:0]  f;
    logic        taken;
    op = prog[i];
    f  = pflg[i];
    case (op[15:14])
      2'b00: begin
        push_ev(pk(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1, op);
        push_ev(pk(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, op);
      end
      2'b01: begin
        for (int k = 0; k < AB; k++)
          push_ev(pk(1'b1, 1'b0, 2'b00, 2'(1) << (AB - 1 - k), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
                  1'b1, op);
        if (op[13]) push_ev(pk(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, op);
        else        push_ev(pk(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, op);
      end
      2'b10: begin
        for (int k = 0; k < AB; k++)
          push_ev(pk(1'b1, 1'b0, 2'b00, 2'b00, 2'(1) << (AB - 1 - k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
                  1'b1, op);
        // f = {neg, zero, carry}
        taken = (op[1:0] == 2'd0) || (op[1:0] == 2'd1 && f[0]) ||
                (op[1:0] == 2'd2 && f[1]) || (op[1:0] == 2'd3 && f[2]);
        if (taken) push_ev(pk(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, op);
      end
      default: ;
    endcase
  endtask

  // Monitor: per-cycle invariants plus in-order event comparison against the scoreboard.
  always @(negedge clk) begin
    if (sb_en) begin
      ev_t e;
      logic trig;
      chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      chk("load_onehot0", 32'($onehot0({ir_load, mar_load, jr_load})), 32'd1);
      chk("strobe_gated", 32'((pc_increment | (|{ir_load, mar_load, jr_load})) & ~mem_ready), 32'd0);
      trig = ((mem_read | mem_write) & mem_ready) | latch_alu | pc_set | gp_read;
      if (trig) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none at %0t",
                   pk(mem_read, mem_write, ir_load, mar_load, jr_load, pc_increment, pc_set,
                      gp_read, gp_write, latch_alu), $time);
        end else begin
          e = exp_q.pop_front();
          chk("event_strobes", 32'(pk(mem_read, mem_write, ir_load, mar_load, jr_load, pc_increment,
                                      pc_set, gp_read, gp_write, latch_alu)), 32'(e.strb));
          if (e.chk)
            chk("event_selects", 32'({alu_operation, gp_input_select, gp_output_select}), 32'(e.sel));
        end
      end
      if (ir_load[0] && mem_ready) ir_done = 1'b1;
    end
  end

  // Driver: presents the next instruction once its last IR byte is loaded; random mem_ready.
  always @(posedge clk) begin
    if (run) begin
      #1;
      if (ir_done && idx < NI - 1) begin
        ir_done   = 1'b0;
        idx       = idx + 1;
        opcode    = prog[idx];
        alu_flags = pflg[idx];
        push_exec(idx);
        if (prog[idx][15:14] != 2'b11) push_fetch();
      end
      if (zrun >= 4) begin
        mem_ready = 1'b1;
        zrun      = 0;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
        zrun      = mem_ready ? 0 : zrun + 1;
      end
    end
  end

  initial begin
    int c;
    reset_n = 1'b0; mem_ready = 1'b0; opcode = 16'h0000; alu_flags = 3'b000;
    run = 1'b0; sb_en = 1'b0; ir_done = 1'b0; idx = -1; zrun = 0; checks = 0; errors = 0;
    for (int i = 0; i < NI; i++) begin
      prog[i] = 16'($urandom);
      prog[i][15:14] = (i == NI - 1) ? 2'b11 : 2'($urandom_range(0, 2));
      pflg[i] = 3'($urandom);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ir_load", 32'(ir_load), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("first_fetch_req", 32'(mem_read), 32'd1);
    chk("first_fetch_busy", 32'(busy), 32'd1);
    chk("fetch_stall_ir", 32'(ir_load), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("fetch_b0_ir", 32'(ir_load), 32'h2);
    chk("fetch_b0_pcinc", 32'(pc_increment), 32'd1);
    @(posedge clk); #1;
    chk("fetch_b1_ir", 32'(ir_load), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("midbeat_rst_ir", 32'(ir_load), 32'd0);
    chk("midbeat_rst_req", 32'(mem_read), 32'd0);
    chk("midbeat_rst_busy", 32'(busy), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("refetch_b0_ir", 32'(ir_load), 32'h2);

    // Memory stuck not-ready during FETCH.
    reset_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    for (int w = 1; w < TO; w++) begin
      @(posedge clk); #1;
    end
    chk("stall_pre_fault", 32'(fault), 32'd0);
    chk("stall_pre_req", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
`ifdef CTRL_MEM_TIMEOUT_EN
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_req", 32'(mem_read), 32'd0);
    mem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("fault_sticky", 32'(fault), 32'd1);
`else
    repeat (20) @(posedge clk);
    #1;
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_fault", 32'(fault), 32'd0);
    chk("stall_req", 32'(mem_read), 32'd1);
    chk("stall_ir", 32'(ir_load), 32'd0);
`endif

    // Random program run under the scoreboard.
    reset_n = 1'b0; mem_ready = 1'b0; opcode = 16'h0000;
    push_fetch();
    @(negedge clk);
    ir_done = 1'b0;
    sb_en   = 1'b1;
    run     = 1'b1;
    reset_n = 1'b1;
    c = 0;
    while (c < 20000 && !(idx == NI - 1 && exp_q.size() == 0)) begin
      @(posedge clk);
      c++;
    end
    chk("program_complete", 32'(idx == NI - 1 && exp_q.size() == 0), 32'd1);
    repeat (3) @(negedge clk);
    for (int h = 0; h < 100; h++) begin
      @(negedge clk);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_no_req", 32'(mem_read | mem_write), 32'd0);
    end
    chk("halt_queue_empty", 32'(exp_q.size()), 32'd0);
    run   = 1'b0;
    sb_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
